i2c_target_regs: RTL and testbench

- I2C responder (target) that exposes a small byte-addressed register file to an external I2C initiator, such as a host-side USB-I2C adapter or a companion MCU.
- It is the far end of the I2C link driven by our uart_i2c_bridge: the bridge initiates transactions and this block answers them.
- Register contents drive the 32-bit `settings` word used by the capture top (bit 19 = dword_enable), and the block returns status to the host.
- Single clock domain: oversamples SCL/SDA; no clock stretching.

---
 rtl/i2c_target_pkg.sv | 37 +++
 rtl/i2c_line_filter.sv | 66 ++++++
 rtl/i2c_target_regs.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// ============================================================
// i2c_target_pkg : shared state encoding and register indices
// Rev 1.0
// ============================================================
`default_nettype none

package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_e;

  localparam logic [2:0] REG_SETTINGS0 = 3'd0;
  localparam logic [2:0] REG_SETTINGS1 = 3'd1;
  localparam logic [2:0] REG_SETTINGS2 = 3'd2;
  localparam logic [2:0] REG_SETTINGS3 = 3'd3;
  localparam logic [2:0] REG_STATUS_LO = 3'd4;
  localparam logic [2:0] REG_STATUS_HI = 3'd5;
  localparam logic [2:0] REG_VERSION   = 3'd6;
  localparam logic [2:0] REG_SCRATCH   = 3'd7;

  function automatic logic reg_writable(input logic [2:0] idx);
    return (idx <= REG_SETTINGS3) || (idx == REG_SCRATCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================
// i2c_line_filter : 2-FF synchronizer, glitch filter, edge pulses
// Rev 1.0
// ============================================================
`default_nettype none

module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], line_in};
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    // Level only follows after FILTER_CYCLES consecutive differing samples.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// ============================================================
// i2c_target_regs : I2C target exposing an 8-byte register file
// Rev 1.0
// ============================================================
`default_nettype none

module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR      = 7'h42,
  parameter int          FILTER_CYCLES = 3,
  parameter logic [31:0] SETTINGS_RST  = 32'h0000_0000,
  parameter logic [7:0]  VERSION       = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] settings,
  input  logic [15:0] status_in,
  output logic        wr_strobe,
  output logic [2:0]  wr_index
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk(clk), .rst_n(rst_n), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk(clk), .rst_n(rst_n), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_phase_q, ack_phase_d;
  logic        rw_q, rw_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [31:0] settings_q, settings_d;
  logic [7:0]  scratch_q, scratch_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [2:0]  wr_index_q, wr_index_d;

  logic       bus_start, bus_stop;
  logic [7:0] shift_in;
  logic [7:0] rd_byte;

  assign bus_start = sda_fall & scl_lvl;
  assign bus_stop  = sda_rise & scl_lvl;
  assign shift_in  = {shift_q[6:0], sda_lvl};

  always_comb begin
    case (ptr_q)
      REG_SETTINGS0: rd_byte = settings_q[7:0];
      REG_SETTINGS1: rd_byte = settings_q[15:8];
      REG_SETTINGS2: rd_byte = settings_q[23:16];
      REG_SETTINGS3: rd_byte = settings_q[31:24];
      REG_STATUS_LO: rd_byte = status_in[7:0];
      REG_STATUS_HI: rd_byte = status_in[15:8];
      REG_VERSION:   rd_byte = VERSION;
      default:       rd_byte = scratch_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    settings_d  = settings_q;
    scratch_d   = scratch_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;

    if (bus_start) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (bus_stop) begin
      state_d     = ST_IDLE;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = sda_lvl;
            state_d = (shift_in[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
          // First fall pulls SDA for the ACK slot, second fall ends it.
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              shift_d  = {rd_byte[6:0], 1'b0};
              sda_oe_d = ~rd_byte[7];
              ptr_d    = ptr_q + 3'd1;
              state_d  = ST_RD_DATA;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
        ST_PTR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = shift_in[2:0];
            state_d = ST_PTR_ACK;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (reg_writable(ptr_q)) begin
              if (ptr_q == REG_SCRATCH) scratch_d = shift_in;
              else settings_d[{ptr_q[1:0], 3'b000} +: 8] = shift_in;
              wr_strobe_d = 1'b1;
              wr_index_d  = ptr_q;
            end
            ptr_d   = ptr_q + 3'd1;
            state_d = ST_WR_ACK;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
          end
        end
        ST_RD_ACK: begin
          // ack_phase_q marks an initiator ACK; the next fall loads the next byte.
          if (scl_fall) begin
            if (ack_phase_q) begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd0;
              shift_d     = {rd_byte[6:0], 1'b0};
              sda_oe_d    = ~rd_byte[7];
              ptr_d       = ptr_q + 3'd1;
              state_d     = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (sda_lvl) state_d = ST_IGNORE;
            else         ack_phase_d = 1'b1;
          end
        end
        ST_IDLE, ST_IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= 3'd0;
      settings_q  <= SETTINGS_RST;
      scratch_q   <= 8'h00;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      settings_q  <= settings_d;
      scratch_q   <= scratch_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign settings  = settings_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// ============================================================
// tb_i2c_target_regs : directed bench for i2c_target_regs
// Rev 1.0
// ============================================================
`default_nettype none

module tb_i2c_target_regs;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_drv;
  logic        sda_drv;
  logic [15:0] status_in;
  logic        sda_oe;
  logic [31:0] settings;
  logic        wr_strobe;
  logic [2:0]  wr_index;
  logic        sda_bus;

  int n_cmp = 0;
  int n_fail = 0;
  int strobe_n = 0;
  int oe_cnt = 0;
  logic [2:0] strobe_log [0:63];

  assign sda_bus = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(
    .I2C_ADDR(7'h42), .FILTER_CYCLES(3), .SETTINGS_RST(32'h0000_0000), .VERSION(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_drv), .sda_in(sda_bus), .sda_oe(sda_oe),
    .settings(settings), .status_in(status_in), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_log[strobe_n[5:0]] <= wr_index;
      strobe_n <= strobe_n + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_q(1);
    scl_drv = 1'b1; wait_q(1);
    sda_drv = 1'b0; wait_q(1);
    scl_drv = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q(1);
    scl_drv = 1'b1; wait_q(1);
    sda_drv = 1'b1; wait_q(1);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n, input bit glitch);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i];
      if (glitch) begin
        repeat (3) @(posedge clk); #1;
        scl_drv = 1'b1; @(posedge clk); #1; scl_drv = 1'b0;
      end
      wait_q(1);
      scl_drv = 1'b1;
      if (glitch) begin
        repeat (3) @(posedge clk); #1;
        sda_drv = ~b[i]; @(posedge clk); #1; sda_drv = b[i];
      end
      wait_q(2);
      scl_drv = 1'b0; wait_q(1);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    write_bits(b, 8, glitch);
    sda_drv = 1'b1; wait_q(1);
    scl_drv = 1'b1; wait_q(1);
    ack = sda_bus; wait_q(1);
    scl_drv = 1'b0; wait_q(1);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    sda_drv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_q(1); scl_drv = 1'b1;
      wait_q(1); b = {b[6:0], sda_bus};
      wait_q(1); scl_drv = 1'b0;
      wait_q(1);
    end
    sda_drv = nack; wait_q(1);
    scl_drv = 1'b1; wait_q(2);
    scl_drv = 1'b0; wait_q(1);
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (settings !== 32'h0) begin n_fail++; $display("FAIL reset_settings: got %h want 00000000", settings); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_cmp++; if (wr_index !== 3'd0) begin n_fail++; $display("FAIL reset_wr_index: got %0d want 0", wr_index); end
    rst_n = 1'b1;
    wait_q(2);
  endtask

  task automatic test_write();
    logic [5:0] acks;
    logic a;
    int s0;
    s0 = strobe_n;
    i2c_start();
    write_byte(8'h84, 1'b0, a); acks[0] = a;
    write_byte(8'h00, 1'b0, a); acks[1] = a;
    write_byte(8'h78, 1'b0, a); acks[2] = a;
    write_byte(8'h56, 1'b0, a); acks[3] = a;
    write_byte(8'h34, 1'b0, a); acks[4] = a;
    write_byte(8'h12, 1'b0, a); acks[5] = a;
    i2c_stop();
    n_cmp++; if (acks !== 6'b0) begin n_fail++; $display("FAIL write_acks: got %b want 000000", acks); end
    n_cmp++; if (settings !== 32'h1234_5678) begin n_fail++; $display("FAIL write_settings: got %h want 12345678", settings); end
    n_cmp++; if (strobe_n - s0 !== 4) begin n_fail++; $display("FAIL write_strobe_count: got %0d want 4", strobe_n - s0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (strobe_log[(s0 + i) % 64] !== 3'(i)) begin
        n_fail++; $display("FAIL write_index[%0d]: got %0d want %0d", i, strobe_log[(s0 + i) % 64], i);
      end
    end
  endtask

  task automatic test_combined_read();
    logic [2:0] acks;
    logic a;
    logic [7:0] b0, b1, b2;
    i2c_start();
    write_byte(8'h84, 1'b0, a); acks[0] = a;
    write_byte(8'h04, 1'b0, a); acks[1] = a;
    i2c_start();
    write_byte(8'h85, 1'b0, a); acks[2] = a;
    read_byte(1'b0, b0);
    read_byte(1'b0, b1);
    read_byte(1'b1, b2);
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    i2c_stop();
    n_cmp++; if (acks !== 3'b0) begin n_fail++; $display("FAIL read_acks: got %b want 000", acks); end
    n_cmp++; if (b0 !== 8'hEF) begin n_fail++; $display("FAIL read_byte0: got %h want ef", b0); end
    n_cmp++; if (b1 !== 8'hBE) begin n_fail++; $display("FAIL read_byte1: got %h want be", b1); end
    n_cmp++; if (b2 !== 8'h01) begin n_fail++; $display("FAIL read_byte2: got %h want 01", b2); end
  endtask

  task automatic test_mismatch();
    logic [2:0] acks;
    logic a;
    int oe0;
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h86, 1'b0, a); acks[0] = a;
    write_byte(8'h00, 1'b0, a); acks[1] = a;
    i2c_stop();
    i2c_start();
    write_byte(8'h00, 1'b0, a); acks[2] = a;
    i2c_stop();
    n_cmp++; if (acks !== 3'b111) begin n_fail++; $display("FAIL mismatch_acks: got %b want 111", acks); end
    n_cmp++; if (oe_cnt != oe0) begin n_fail++; $display("FAIL mismatch_sda_oe_cycles: got %0d want 0", oe_cnt - oe0); end
    n_cmp++; if (settings !== 32'h1234_5678) begin n_fail++; $display("FAIL mismatch_settings: got %h want 12345678", settings); end
  endtask

  task automatic test_wrap_ro();
    logic [5:0] acks;
    logic a;
    logic [7:0] r6, r7;
    int s0;
    s0 = strobe_n;
    i2c_start();
    write_byte(8'h84, 1'b0, a); acks[0] = a;
    write_byte(8'h06, 1'b0, a); acks[1] = a;
    write_byte(8'hAA, 1'b0, a); acks[2] = a;
    write_byte(8'h55, 1'b0, a); acks[3] = a;
    write_byte(8'h11, 1'b0, a); acks[4] = a;
    i2c_start();
    write_byte(8'h84, 1'b0, a); acks[5] = a;
    write_byte(8'h06, 1'b0, a);
    i2c_start();
    write_byte(8'h85, 1'b0, a);
    read_byte(1'b0, r6);
    read_byte(1'b1, r7);
    i2c_stop();
    n_cmp++; if (acks !== 6'b0) begin n_fail++; $display("FAIL wrap_acks: got %b want 000000", acks); end
    n_cmp++; if (strobe_n - s0 !== 2) begin n_fail++; $display("FAIL wrap_strobe_count: got %0d want 2", strobe_n - s0); end
    n_cmp++; if (strobe_log[s0 % 64] !== 3'd7) begin n_fail++; $display("FAIL wrap_index0: got %0d want 7", strobe_log[s0 % 64]); end
    n_cmp++; if (strobe_log[(s0 + 1) % 64] !== 3'd0) begin n_fail++; $display("FAIL wrap_index1: got %0d want 0", strobe_log[(s0 + 1) % 64]); end
    n_cmp++; if (settings !== 32'h1234_5611) begin n_fail++; $display("FAIL wrap_settings: got %h want 12345611", settings); end
    n_cmp++; if (r6 !== 8'h01) begin n_fail++; $display("FAIL wrap_reg6: got %h want 01", r6); end
    n_cmp++; if (r7 !== 8'h55) begin n_fail++; $display("FAIL wrap_reg7: got %h want 55", r7); end
  endtask

  task automatic test_glitch_abort();
    logic [2:0] acks;
    logic a;
    logic [7:0] r7;
    int s0, s1;
    s0 = strobe_n;
    i2c_start();
    write_byte(8'h84, 1'b0, a); acks[0] = a;
    write_byte(8'h07, 1'b0, a);
    write_byte(8'h3C, 1'b1, a); acks[1] = a;
    i2c_stop();
    n_cmp++; if (strobe_n - s0 !== 1) begin n_fail++; $display("FAIL glitch_strobe_count: got %0d want 1", strobe_n - s0); end
    n_cmp++; if (strobe_log[s0 % 64] !== 3'd7) begin n_fail++; $display("FAIL glitch_index: got %0d want 7", strobe_log[s0 % 64]); end
    s1 = strobe_n;
    i2c_start();
    write_byte(8'h84, 1'b0, a);
    write_byte(8'h07, 1'b0, a);
    write_bits(8'hFF, 4, 1'b0);
    i2c_stop();
    n_cmp++; if (strobe_n - s1 !== 0) begin n_fail++; $display("FAIL abort_strobe_count: got %0d want 0", strobe_n - s1); end
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
    i2c_start();
    write_byte(8'h85, 1'b0, a); acks[2] = a;
    read_byte(1'b1, r7);
    i2c_stop();
    n_cmp++; if (acks !== 3'b0) begin n_fail++; $display("FAIL glitch_acks: got %b want 000", acks); end
    n_cmp++; if (r7 !== 8'h3C) begin n_fail++; $display("FAIL glitch_reg7: got %h want 3c", r7); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic [7:0] rb;
    logic [63:0] got;
    i2c_start();
    write_byte(8'h84, 1'b0, a);
    write_byte(8'h00, 1'b0, a);
    i2c_start();
    write_byte(8'h85, 1'b0, a);
    n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving: got %b want 1", sda_oe); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_async_release: got %b want 0", sda_oe); end
    n_cmp++; if (settings !== 32'h0) begin n_fail++; $display("FAIL midread_settings: got %h want 00000000", settings); end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    wait_q(1);
    i2c_stop();
    got = 64'h0;
    i2c_start();
    write_byte(8'h85, 1'b0, a);
    for (int i = 0; i < 8; i++) begin
      read_byte(i == 7, rb);
      got = {got[55:0], rb};
    end
    i2c_stop();
    n_cmp++; if (a !== 1'b0) begin n_fail++; $display("FAIL postreset_addr_ack: got %b want 0", a); end
    n_cmp++; if (got !== 64'h0000_0000_EFBE_0100) begin n_fail++; $display("FAIL postreset_dump: got %h want 00000000efbe0100", got); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    scl_drv   = 1'b1;
    sda_drv   = 1'b1;
    status_in = 16'hBEEF;
    test_reset();
    test_write();
    test_combined_read();
    test_mismatch();
    test_wrap_ro();
    test_glitch_abort();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
